// File: rtl/logic_fn_sweeper.sv
// logic_fn_sweeper: sequences a 5-in/4-out combinational function unit.
// Mode 0 sweeps all 32 input vectors and counts the on-set of each output.
// Mode 1 applies one vector and captures the four outputs.
// Each vector is held SETTLE cycles (legal 1..15) before it is sampled.
module logic_fn_sweeper #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  input  logic [4:0] vec_in,
  input  logic       hold,
  input  logic       abort,
  output logic [4:0] fu_in,
  input  logic [3:0] fu_out,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic [3:0] result,
  output logic [5:0] cnt_f1,
  output logic [5:0] cnt_f2,
  output logic [5:0] cnt_f3,
  output logic [5:0] cnt_f4
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Settle counter runs SETTLE-1 down to 0; the capture happens on the zero cycle.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_settle;
  logic [4:0] r_index;
  logic       r_mode;
  logic [4:0] r_fu_in;
  logic [3:0] r_result;
  logic       r_aborted;
  logic [5:0] w_cnt [4];

  logic w_start_op;
  logic w_abort_op;
  logic w_tick;
  logic w_capture;
  logic w_last;

  assign w_last = (r_index == 5'd31);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state and per-cycle action decode; abort outranks hold and capture.
  always_comb begin
    w_state_next = r_state;
    w_start_op   = 1'b0;
    w_abort_op   = 1'b0;
    w_tick       = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_start_op   = 1'b1;
          w_state_next = ST_APPLY;
        end
      end
      ST_APPLY: begin
        if (abort) begin
          w_abort_op   = 1'b1;
          w_state_next = ST_IDLE;
        end else if (!hold) begin
          if (r_settle != 4'd0) begin
            w_tick = 1'b1;
          end else begin
            w_capture = 1'b1;
            if (r_mode || w_last) w_state_next = ST_DONE;
          end
        end
      end
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Vector sequencing, settle timing, query capture and abort pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle  <= '0;
      r_index   <= '0;
      r_mode    <= 1'b0;
      r_fu_in   <= '0;
      r_result  <= '0;
      r_aborted <= 1'b0;
    end else begin
      r_aborted <= w_abort_op;
      if (w_start_op) begin
        r_mode   <= mode;
        r_settle <= SETTLE_LOAD;
        if (!mode) begin
          r_index <= '0;
          r_fu_in <= '0;
        end else begin
          r_fu_in <= vec_in;
        end
      end else if (w_tick) begin
        r_settle <= r_settle - 4'd1;
      end else if (w_capture) begin
        if (r_mode) begin
          r_result <= fu_out;
        end else if (!w_last) begin
          r_index  <= r_index + 5'd1;
          r_fu_in  <= r_index + 5'd1;
          r_settle <= SETTLE_LOAD;
        end
      end
    end
  end

  // One on-set counter per function output; fu_out bit 3 is F1.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cnt
      logic [5:0] r_cnt;
      // Cleared by a sweep start, bumped on each sweep capture with F=1.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 r_cnt <= '0;
        else if (w_start_op && !mode)               r_cnt <= '0;
        else if (w_capture && !r_mode && fu_out[3-gi]) r_cnt <= r_cnt + 6'd1;
      end
      assign w_cnt[gi] = r_cnt;
    end
  endgenerate

  assign fu_in   = r_fu_in;
  assign busy    = (r_state == ST_APPLY);
  assign done    = (r_state == ST_DONE);
  assign aborted = r_aborted;
  assign result  = r_result;
  assign cnt_f1  = w_cnt[0];
  assign cnt_f2  = w_cnt[1];
  assign cnt_f3  = w_cnt[2];
  assign cnt_f4  = w_cnt[3];

endmodule

// File: doc/logic_fn_sweeper.md
Name: logic_fn_sweeper

Overview:
- Sequencer for the team's 5-input / 4-output combinational function unit (inputs A..E, outputs F1..F4).
- Drives the unit's inputs, waits a programmable settle time, and samples the outputs.
- Two modes: a full 32-vector truth-table sweep that counts the on-set size of each function, or a single-vector query.
- Sits between the lab control logic (start/done handshake) and the function unit. The function unit is instantiated beside this block, not inside it.

Parameters:
- SETTLE, default 2, number of cycles each vector is held before sampling. Legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an operation; honoured only in IDLE.
- mode  input  1  0 = full sweep, 1 = single query.
- vec_in  input  5  query vector {A,B,C,D,E}, bit4 = A; sampled with start.
- hold  input  1  freezes the sweep while high.
- abort  input  1  terminates an operation in progress.
- fu_in  output  5  drive to the function unit {A,B,C,D,E}.
- fu_out  input  4  function unit outputs {F1,F2,F3,F4}, bit3 = F1.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse on normal completion.
- aborted  output  1  one-cycle pulse when an abort is taken.
- result  output  4  fu_out captured by the last single query.
- cnt_f1, cnt_f2, cnt_f3, cnt_f4  output  6 each  number of sweep vectors with F=1 (range 0..32).

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, fu_in=0, busy=0, done=0, aborted=0, result=0, all cnt_*=0, internal index=0, settle counter=0.
- States: IDLE, APPLY, DONE.
- IDLE with start=1 (abort ignored in IDLE):
  - mode=0: clear all cnt_*, set index=0, fu_in=0.
  - mode=1: fu_in=vec_in.
  - Either mode: settle counter=SETTLE-1, go to APPLY.
- APPLY: busy=1.
  - Settle counter nonzero and hold=0: decrement the counter.
  - Settle counter zero and hold=0 (capture edge):
    - mode=0: each cnt_fN increments if its fu_out bit is 1. If index=31, go to DONE. Otherwise index+1, fu_in=index+1, counter reloads to SETTLE-1.
    - mode=1: result=fu_out, go to DONE.
  - hold=1: counter, index and fu_in frozen, no capture.
- Mode is latched at start; changes to mode or vec_in during APPLY are ignored.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. start in DONE is ignored.
- Timing: sweep start edge to done-high cycle is 32*SETTLE cycles (hold=0). Query is SETTLE cycles.
- abort=1 in APPLY: next state is IDLE, aborted pulses 1 cycle, done stays 0.
  - cnt_* keep their partial values; result is unchanged.
  - abort has priority over hold and over a capture in the same cycle (that capture is not counted).
- start while busy is ignored; it is not queued.
- fu_in keeps the last applied vector in IDLE/DONE until the next start or reset.
- Counter width: 6 bits, no saturation needed (maximum 32).
- rst_n asserted mid-operation returns everything to reset values immediately. No done or aborted pulse.

Test Plan:
- Reset, then mode=0 start with SETTLE=2 and the real function unit attached -> done exactly 64 cycles after the start edge; cnt_f1=12, cnt_f2=20, cnt_f3=14, cnt_f4=15; busy low in the done cycle.
- mode=1, vec_in=5'b11000 -> result=4'b1000 after 2 cycles, done pulse. Then vec_in=5'b10011 -> result=4'b0011.
- Sweep with hold=1 for 10 cycles while index=5 -> fu_in stays 5'b00101, done arrives at 74 cycles, counts unchanged from the no-hold run.
- abort asserted at cycle 20 of a sweep -> aborted pulse, no done, cnt_* equal counts for vectors 0..9 only. A restart then clears the counts and finishes with 12/20/14/15.
- start pulsed repeatedly during a sweep, plus start coincident with DONE -> ignored, exactly one done. abort+start together in IDLE -> operation starts.
- rst_n dropped mid-sweep (index 17) -> all outputs immediately 0, FSM in IDLE; a fresh sweep gives correct counts.
